mc_controller: RTL and testbench

Multicycle RISC-V control unit: the successor to the single-cycle decoder, driving a shared-memory, shared-ALU datapath one micro-step per clock. It sits between the instruction register fields and the multicycle datapath muxes and enables. It adds a memory ready/request handshake with a parametrised timeout, `bne`/`jal`/I-type ALU support, a sticky fault state and a retired-instruction counter.

---
 rtl/mc_pkg.sv | 65 ++++++
 rtl/mc_if.sv | 10 +
 rtl/mc_aludec.sv | 26 ++
 rtl/mc_controller.sv | 200 ++++++++++++++++++++
 tb/tb_mc_controller.sv | 337 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mc_pkg.sv
// Shared types and encodings for the multicycle RISC-V control unit.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BRANCH,
    S_JAL,
    S_FAULT
  } state_t;

  localparam logic [6:0] OP_LW     = 7'b0000011;
  localparam logic [6:0] OP_SW     = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [2:0] ALU_SLL = 3'b110;
  localparam logic [2:0] ALU_SRL = 3'b111;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  function automatic logic [1:0] imm_decode(input logic [6:0] opcode);
    case (opcode)
      OP_SW:     imm_decode = IMM_S;
      OP_BRANCH: imm_decode = IMM_B;
      OP_JAL:    imm_decode = IMM_J;
      default:   imm_decode = IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/mc_if.sv
// Memory request/ready handshake between the controller and the shared memory port.
interface mc_if;
  logic mem_req;
  logic mem_write;
  logic adr_src;
  logic mem_ready;

  modport master (output mem_req, output mem_write, output adr_src, input mem_ready);
  modport slave  (input mem_req, input mem_write, input adr_src, output mem_ready);
endinterface

// File: rtl/mc_aludec.sv
// Combinational funct3/funct7 to ALU operation decode for register and immediate ALU ops.
module mc_aludec
  import mc_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       op5,
  output logic [2:0] alu_control
);

  always_comb begin
    alu_control = ALU_ADD;
    case (funct3)
      // op5 separates R-type from I-type so addi with imm[10]=1 stays an add
      3'b000:  alu_control = (funct7b5 & op5) ? ALU_SUB : ALU_ADD;
      3'b010:  alu_control = ALU_SLT;
      3'b110:  alu_control = ALU_OR;
      3'b111:  alu_control = ALU_AND;
      3'b100:  alu_control = ALU_XOR;
      3'b001:  alu_control = ALU_SLL;
      3'b101:  alu_control = ALU_SRL;
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multicycle RISC-V control FSM: one datapath micro-step per clock, memory waits
// bounded by WAIT_LIMIT, sticky fault state and retired-instruction counter.
module mc_controller
  import mc_pkg::*;
#(
  parameter int WAIT_LIMIT = 16,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             reset,
  mc_if.master             mem,
  input  logic [6:0]       op,
  input  logic [2:0]       funct3,
  input  logic             funct7b5,
  input  logic             zero,
  output logic             ir_write,
  output logic             pc_write,
  output logic             reg_write,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       result_src,
  output logic [1:0]       imm_src,
  output logic [2:0]       alu_control,
  output logic             fault,
  output logic [1:0]       fault_cause,
  output logic [CNT_W-1:0] instret
);

  localparam int WAIT_W = (WAIT_LIMIT < 2) ? 1 : $clog2(WAIT_LIMIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(WAIT_LIMIT);

  state_t            state, state_next;
  logic [WAIT_W-1:0] wait_cnt, wait_inc;
  logic [1:0]        cause_next;
  logic [2:0]        alu_fn;
  logic              waiting, timeout, retire;

  mc_aludec u_aludec (
    .funct3      (funct3),
    .funct7b5    (funct7b5),
    .op5         (op[5]),
    .alu_control (alu_fn)
  );

  assign waiting  = ((state == S_FETCH) || (state == S_MEMREAD) || (state == S_MEMWRITE))
                    && !mem.mem_ready;
  assign wait_inc = wait_cnt + WAIT_W'(1);
  // Fires in the WAIT_LIMIT-th consecutive unready cycle, so FAULT follows on that edge.
  assign timeout  = (WAIT_LIMIT != 0) && waiting && (wait_inc == WAIT_MAX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_FETCH;
      wait_cnt    <= '0;
      fault_cause <= CAUSE_NONE;
      instret     <= '0;
    end else begin
      state       <= state_next;
      wait_cnt    <= (waiting && !timeout) ? wait_inc : '0;
      fault_cause <= cause_next;
      if (retire) instret <= instret + CNT_W'(1);
    end
  end

  always_comb begin
    state_next = state;
    cause_next = fault_cause;
    retire     = 1'b0;
    case (state)
      S_FETCH: begin
        if (timeout) begin
          state_next = S_FAULT;
          cause_next = CAUSE_TIMEOUT;
        end else if (mem.mem_ready) begin
          state_next = S_DECODE;
        end
      end
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_RTYPE:     state_next = S_EXECR;
          OP_ITYPE:     state_next = S_EXECI;
          OP_BRANCH:    state_next = S_BRANCH;
          OP_JAL:       state_next = S_JAL;
          default: begin
            state_next = S_FAULT;
            cause_next = CAUSE_ILLEGAL;
          end
        endcase
      end
      S_MEMADR: state_next = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD: begin
        if (timeout) begin
          state_next = S_FAULT;
          cause_next = CAUSE_TIMEOUT;
        end else if (mem.mem_ready) begin
          state_next = S_MEMWB;
        end
      end
      S_MEMWRITE: begin
        if (timeout) begin
          state_next = S_FAULT;
          cause_next = CAUSE_TIMEOUT;
        end else if (mem.mem_ready) begin
          state_next = S_FETCH;
          retire     = 1'b1;
        end
      end
      S_MEMWB, S_ALUWB: begin
        state_next = S_FETCH;
        retire     = 1'b1;
      end
      S_EXECR, S_EXECI: state_next = S_ALUWB;
      S_BRANCH: begin
        if ((funct3 == 3'b000) || (funct3 == 3'b001)) begin
          state_next = S_FETCH;
          retire     = 1'b1;
        end else begin
          state_next = S_FAULT;
          cause_next = CAUSE_ILLEGAL;
        end
      end
      S_JAL:   state_next = S_ALUWB;
      S_FAULT: state_next = S_FAULT;
      default: state_next = S_FAULT;
    endcase
  end

  always_comb begin
    mem.mem_req   = 1'b0;
    mem.mem_write = 1'b0;
    mem.adr_src   = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = SRCA_PC;
    alu_src_b     = SRCB_RS2;
    result_src    = RES_ALUOUT;
    imm_src       = IMM_I;
    alu_control   = ALU_ADD;
    fault         = 1'b0;
    if (!reset) begin
      imm_src = imm_decode(op);
      case (state)
        S_FETCH: begin
          mem.mem_req = 1'b1;
          ir_write    = mem.mem_ready;
          pc_write    = mem.mem_ready;
          alu_src_b   = SRCB_FOUR;
          result_src  = RES_ALURESULT;
        end
        S_DECODE: begin
          alu_src_a = SRCA_OLDPC;
          alu_src_b = SRCB_IMM;
        end
        S_MEMADR: begin
          alu_src_a = SRCA_RS1;
          alu_src_b = SRCB_IMM;
        end
        S_MEMREAD: begin
          mem.mem_req = 1'b1;
          mem.adr_src = 1'b1;
        end
        S_MEMWB: begin
          result_src = RES_DATA;
          reg_write  = 1'b1;
        end
        S_MEMWRITE: begin
          mem.mem_req   = 1'b1;
          mem.mem_write = 1'b1;
          mem.adr_src   = 1'b1;
        end
        S_EXECR: begin
          alu_src_a   = SRCA_RS1;
          alu_control = alu_fn;
        end
        S_EXECI: begin
          alu_src_a   = SRCA_RS1;
          alu_src_b   = SRCB_IMM;
          alu_control = alu_fn;
        end
        S_ALUWB: reg_write = 1'b1;
        S_BRANCH: begin
          alu_src_a   = SRCA_RS1;
          alu_control = ALU_SUB;
          if (funct3 == 3'b000)      pc_write = zero;
          else if (funct3 == 3'b001) pc_write = ~zero;
        end
        S_JAL: begin
          alu_src_a = SRCA_OLDPC;
          alu_src_b = SRCB_FOUR;
          pc_write  = 1'b1;
        end
        S_FAULT: fault = 1'b1;
        default: fault = 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench: an instruction-level micro-step model checks every output each cycle,
// with hand-computed spot checks along the way.
module tb_mc_controller;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic        funct7b5, zero;

  logic        ir_write, pc_write, reg_write, fault;
  logic [1:0]  alu_src_a, alu_src_b, result_src, imm_src, fault_cause;
  logic [2:0]  alu_control;
  logic [31:0] instret;

  logic        ir_write_z, pc_write_z, reg_write_z, fault_z;
  logic [1:0]  alu_src_a_z, alu_src_b_z, result_src_z, imm_src_z, fault_cause_z;
  logic [2:0]  alu_control_z;
  logic [31:0] instret_z;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mc_if bus ();
  mc_if bus0 ();

  mc_controller #(.WAIT_LIMIT(LIMIT), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .mem(bus), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .result_src(result_src),
    .imm_src(imm_src), .alu_control(alu_control), .fault(fault),
    .fault_cause(fault_cause), .instret(instret)
  );

  mc_controller #(.WAIT_LIMIT(0), .CNT_W(32)) dut0 (
    .clk(clk), .reset(reset), .mem(bus0), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .ir_write(ir_write_z), .pc_write(pc_write_z), .reg_write(reg_write_z),
    .alu_src_a(alu_src_a_z), .alu_src_b(alu_src_b_z), .result_src(result_src_z),
    .imm_src(imm_src_z), .alu_control(alu_control_z), .fault(fault_z),
    .fault_cause(fault_cause_z), .instret(instret_z)
  );

  typedef struct packed {
    logic        mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
    logic [1:0]  a, b, rs, imm;
    logic [2:0]  alu;
    logic        flt;
    logic [1:0]  cause;
    logic [31:0] ir;
  } obs_t;

  // Model: each opcode is a string of micro-steps; F/R/S are memory steps that stall.
  int       m_step, m_instret, m_wait;
  bit       m_fault;
  logic [1:0] m_cause;

  function automatic string prog_of(input logic [6:0] o);
    case (o)
      7'b0000011: return "FDARL";
      7'b0100011: return "FDAS";
      7'b0110011: return "FDXW";
      7'b0010011: return "FDIW";
      7'b1100011: return "FDB";
      7'b1101111: return "FDJW";
      default:    return "FD";
    endcase
  endfunction

  function automatic logic [2:0] alu_ref(input logic [2:0] f3, input logic f7, input logic o5);
    case (f3)
      3'b000:  return (f7 && o5) ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      3'b100:  return 3'b100;
      3'b001:  return 3'b110;
      default: return 3'b111;
    endcase
  endfunction

  function automatic logic [1:0] imm_ref(input logic [6:0] o);
    if (o == 7'b0100011) return 2'b01;
    if (o == 7'b1100011) return 2'b10;
    if (o == 7'b1101111) return 2'b11;
    return 2'b00;
  endfunction

  function automatic obs_t expect_now();
    obs_t  e;
    string p;
    byte   ch;
    e = '0;
    if (reset) return e;
    e.imm   = imm_ref(op);
    e.ir    = 32'(m_instret);
    e.cause = m_cause;
    if (m_fault) begin
      e.flt = 1'b1;
      return e;
    end
    p  = prog_of(op);
    ch = p[m_step];
    case (ch)
      "F": begin
        e.mem_req = 1'b1; e.b = 2'b10; e.rs = 2'b10;
        e.ir_write = bus.mem_ready; e.pc_write = bus.mem_ready;
      end
      "D": begin e.a = 2'b01; e.b = 2'b01; end
      "A": begin e.a = 2'b10; e.b = 2'b01; end
      "R": begin e.mem_req = 1'b1; e.adr_src = 1'b1; end
      "L": begin e.rs = 2'b01; e.reg_write = 1'b1; end
      "S": begin e.mem_req = 1'b1; e.mem_write = 1'b1; e.adr_src = 1'b1; end
      "X": begin e.a = 2'b10; e.alu = alu_ref(funct3, funct7b5, op[5]); end
      "I": begin e.a = 2'b10; e.b = 2'b01; e.alu = alu_ref(funct3, funct7b5, op[5]); end
      "W": e.reg_write = 1'b1;
      "B": begin
        e.a = 2'b10; e.alu = 3'b001;
        e.pc_write = (funct3 == 3'd0) ? zero : ((funct3 == 3'd1) ? ~zero : 1'b0);
      end
      "J": begin e.a = 2'b01; e.b = 2'b10; e.pc_write = 1'b1; end
      default: e = '1;
    endcase
    return e;
  endfunction

  always @(posedge clk) begin
    string p;
    byte   ch;
    if (reset) begin
      m_step = 0; m_instret = 0; m_wait = 0; m_fault = 0; m_cause = 2'b00;
    end else if (!m_fault) begin
      p  = prog_of(op);
      ch = p[m_step];
      if ((ch == "F" || ch == "R" || ch == "S") && !bus.mem_ready) begin
        m_wait++;
        if (LIMIT != 0 && m_wait == LIMIT) begin
          m_fault = 1; m_cause = 2'b10; m_wait = 0;
        end
      end else begin
        m_wait = 0;
        if (ch == "D" && p.len() == 2) begin
          m_fault = 1; m_cause = 2'b01;
        end else if (ch == "B" && funct3 > 3'd1) begin
          m_fault = 1; m_cause = 2'b01;
        end else if (m_step == p.len() - 1) begin
          m_step = 0; m_instret++;
        end else begin
          m_step++;
        end
      end
    end
  end

  always @(negedge clk) begin
    obs_t a, e;
    a = {bus.mem_req, bus.mem_write, bus.adr_src, ir_write, pc_write, reg_write,
         alu_src_a, alu_src_b, result_src, imm_src, alu_control, fault, fault_cause, instret};
    e = expect_now();
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL model t=%0t actual=%h required=%h", $time, a, e);
    end
    n_chk++;
    if (fault_z !== 1'b0 || bus0.mem_req !== !reset) begin
      n_fail++;
      $display("FAIL nolimit t=%0t actual fault=%b req=%b required fault=0 req=%b",
               $time, fault_z, bus0.mem_req, !reset);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic cyc(input bit r);
    bus.mem_ready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7, input logic z);
    op = o; funct3 = f3; funct7b5 = f7; zero = z;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    set_instr(7'b0000011, 3'b010, 1'b0, 1'b0);
    bus.mem_ready = 1'b0;
    bus0.mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_req", bus.mem_req, 0);
    chk("rst_instret", instret, 0);
    chk("rst_fault", fault, 0);
    reset = 1'b0;

    // lw, zero wait: writeback in cycle 5
    repeat (4) cyc(1);
    bus.mem_ready = 1'b1; #1;
    chk("lw_c5_reg_write", reg_write, 1);
    chk("lw_c5_result_src", result_src, 2'b01);
    @(posedge clk); #1;
    chk("lw_instret", instret, 1);
    chk("lw_back_to_fetch", bus.mem_req, 1);

    // sw with three unready cycles in MEMWRITE
    set_instr(7'b0100011, 3'b010, 1'b0, 1'b0);
    repeat (3) cyc(1);
    for (int i = 0; i < 4; i++) begin
      bus.mem_ready = (i == 3); #1;
      chk("sw_mem_req", bus.mem_req, 1);
      chk("sw_mem_write", bus.mem_write, 1);
      chk("sw_adr_src", bus.adr_src, 1);
      chk("sw_no_pc_write", pc_write, 0);
      @(posedge clk); #1;
    end
    chk("sw_instret", instret, 2);

    // beq taken, bne not taken, both with zero=1
    set_instr(7'b1100011, 3'b000, 1'b0, 1'b1);
    cyc(1); cyc(1);
    #1; chk("beq_pc_write", pc_write, 1);
    @(posedge clk); #1;
    chk("beq_instret", instret, 3);
    set_instr(7'b1100011, 3'b001, 1'b0, 1'b1);
    cyc(1); cyc(1);
    #1; chk("bne_pc_write", pc_write, 0);
    @(posedge clk); #1;
    chk("bne_fetch", bus.mem_req, 1);
    chk("bne_instret", instret, 4);

    // R-type sub, addi with funct7b5 set, srli, jal
    set_instr(7'b0110011, 3'b000, 1'b1, 1'b0);
    cyc(1); cyc(1);
    #1; chk("sub_alu", alu_control, 3'b001);
    @(posedge clk); #1; cyc(1);
    set_instr(7'b0010011, 3'b000, 1'b1, 1'b0);
    cyc(1); cyc(1);
    #1; chk("addi_alu", alu_control, 3'b000);
    @(posedge clk); #1; cyc(1);
    set_instr(7'b0010011, 3'b101, 1'b0, 1'b0);
    repeat (4) cyc(1);
    set_instr(7'b1101111, 3'b000, 1'b0, 1'b0);
    cyc(1); cyc(1);
    #1; chk("jal_pc_write", pc_write, 1);
    chk("jal_imm_src", imm_src, 2'b11);
    @(posedge clk); #1;
    #1; chk("jal_wb", reg_write, 1);
    cyc(1);
    chk("jal_instret", instret, 8);

    // fetch stalled for LIMIT-1 cycles: no fault
    set_instr(7'b0110011, 3'b111, 1'b0, 1'b0);
    repeat (3) cyc(0);
    repeat (4) cyc(1);
    chk("stall_no_fault", fault, 0);
    chk("stall_instret", instret, 9);

    // fetch timeout after exactly LIMIT unready cycles
    set_instr(7'b0000011, 3'b010, 1'b0, 1'b0);
    repeat (3) cyc(0);
    chk("tmo_not_yet", fault, 0);
    cyc(0);
    chk("tmo_fault", fault, 1);
    chk("tmo_cause", fault_cause, 2'b10);
    chk("tmo_req_off", bus.mem_req, 0);
    repeat (5) cyc(1);
    #1; chk("tmo_sticky_ir_write", ir_write, 0);
    do_reset();
    #1; chk("tmo_recover", bus.mem_req, 1);

    // illegal opcode faults after DECODE and stays there
    set_instr(7'b0000000, 3'b000, 1'b0, 1'b0);
    repeat (14) cyc(1);
    chk("ill_fault", fault, 1);
    chk("ill_cause", fault_cause, 2'b01);
    chk("ill_reg_write", reg_write, 0);
    chk("ill_pc_write", pc_write, 0);
    do_reset();
    #1; chk("ill_recover_req", bus.mem_req, 1);
    chk("ill_recover_fault", fault, 0);

    // unsupported branch funct3
    set_instr(7'b1100011, 3'b100, 1'b0, 1'b0);
    repeat (3) cyc(1);
    chk("badbr_cause", fault_cause, 2'b01);
    do_reset();

    // reset in the middle of a stalled MEMREAD
    set_instr(7'b0110011, 3'b000, 1'b0, 1'b0);
    repeat (4) cyc(1);
    chk("pre_rst_instret", instret, 1);
    set_instr(7'b0000011, 3'b010, 1'b0, 1'b0);
    repeat (3) cyc(1);
    cyc(0);
    #1; chk("memread_req", bus.mem_req, 1);
    reset = 1'b1; #1;
    chk("midrst_req", bus.mem_req, 0);
    chk("midrst_reg_write", reg_write, 0);
    chk("midrst_instret", instret, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    bus.mem_ready = 1'b1; #1;
    chk("postrst_fetch_req", bus.mem_req, 1);
    chk("postrst_ir_write", ir_write, 1);
    chk("postrst_adr_src", bus.adr_src, 0);
    @(posedge clk); #1;
    repeat (4) cyc(1);
    chk("postrst_lw_instret", instret, 1);

    // long unready stretch: limited DUT times out, unlimited one never does
    repeat (110) cyc(0);
    chk("nolimit_fault", fault_z, 0);
    chk("nolimit_req", bus0.mem_req, 1);
    chk("limit_fault", fault, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
